// File: rtl/addsub_serial_unit_pkg.sv
`default_nettype none
// ============================================================================
// addsub_pkg : shared types and elaboration helpers for addsub_serial_unit
// Rev 1.0
// ============================================================================
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk index width: clog2(N), never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_legal(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_serial_unit_if.sv
`default_nettype none
// ============================================================================
// addsub_serial_unit_if : start/done request bus with operands and flags
// Rev 1.0
// ============================================================================
interface addsub_serial_unit_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic             sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start, sel, a, b,
        input  busy, done, s, cout, ovf, zero, neg
    );

    modport slave (
        input  start, sel, a, b,
        output busy, done, s, cout, ovf, zero, neg
    );
endinterface
`default_nettype wire

// File: rtl/addsub_serial_unit_chunk.sv
`default_nettype none
// ============================================================================
// addsub_chunk : combinational CHUNK-bit add/subtract slice
// Rev 1.0
// ============================================================================
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] a_i,
    input  wire logic [CHUNK-1:0] b_i,
    input  wire logic             sel_i,
    input  wire logic             cin_i,
    output logic      [CHUNK-1:0] s_o,
    output logic                  cout_o,
    output logic                  c_msb_in_o
);
    logic [CHUNK-1:0] bx;
    logic [CHUNK:0]   sum;

    assign bx  = b_i ^ {CHUNK{sel_i}};
    assign sum = {1'b0, a_i} + {1'b0, bx} + {{CHUNK{1'b0}}, cin_i};

    assign s_o    = sum[CHUNK-1:0];
    assign cout_o = sum[CHUNK];
    // Carry into the MSB recovered from the MSB's own sum bit
    assign c_msb_in_o = sum[CHUNK-1] ^ a_i[CHUNK-1] ^ bx[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/addsub_serial_unit.sv
`default_nettype none
// ============================================================================
// addsub_serial_unit : digit-serial add/sub, CHUNK bits per clock, LSB first
// Rev 1.0
// ============================================================================
module addsub_serial_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    addsub_serial_unit_if.slave bus
);
    import addsub_pkg::*;

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = idx_width(N);

    generate
        if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
            $error("addsub_serial_unit: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [WIDTH-1:0] a_d, b_d, acc_d;
    logic             sel_q, carry_q;
    logic [IW-1:0]    k_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q, zero_q, neg_q, busy_q, done_q;

    logic [CHUNK-1:0] sum_chunk;
    logic             carry_chunk, cmsb_chunk;
    logic             last_chunk;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i        (a_q[CHUNK-1:0]),
        .b_i        (b_q[CHUNK-1:0]),
        .sel_i      (sel_q),
        .cin_i      (carry_q),
        .s_o        (sum_chunk),
        .cout_o     (carry_chunk),
        .c_msb_in_o (cmsb_chunk)
    );

    // Operands shift down one chunk per cycle; results enter the accumulator at the top
    generate
        if (N > 1) begin : g_multi
            assign a_d   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
            assign b_d   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
            assign acc_d = {sum_chunk, acc_q[WIDTH-1:CHUNK]};
        end else begin : g_single
            assign a_d   = a_q;
            assign b_d   = b_q;
            assign acc_d = sum_chunk;
        end
    endgenerate

    assign last_chunk = (k_q == IW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sel_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        sel_q   <= bus.sel;
                        carry_q <= bus.sel;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    acc_q   <= acc_d;
                    carry_q <= carry_chunk;
                    k_q     <= k_q + 1'b1;
                    if (last_chunk) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        s_q     <= acc_d;
                        cout_q  <= carry_chunk;
                        ovf_q   <= cmsb_chunk ^ carry_chunk;
                        zero_q  <= (acc_d == '0);
                        neg_q   <= acc_d[WIDTH-1];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
endmodule
`default_nettype wire

// File: tb/tb_addsub_serial_unit.sv
`default_nettype none
// ============================================================================
// tb_addsub_serial_unit : directed vectors for addsub_serial_unit (16/4, 8/8, 8/1)
// Rev 1.0
// ============================================================================
module tb_addsub_serial_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    addsub_serial_unit_if #(.WIDTH(16)) bus16 ();
    addsub_serial_unit_if #(.WIDTH(8))  bus8 ();
    addsub_serial_unit_if #(.WIDTH(8))  bus1 ();

    addsub_serial_unit #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    addsub_serial_unit #(.WIDTH(8),  .CHUNK(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    addsub_serial_unit #(.WIDTH(8),  .CHUNK(1)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res16(input string tag, input logic [15:0] s, input logic c,
                             input logic o, input logic z, input logic n);
        chk({tag, "_s"},    32'(bus16.s),    32'(s));
        chk({tag, "_cout"}, 32'(bus16.cout), 32'(c));
        chk({tag, "_ovf"},  32'(bus16.ovf),  32'(o));
        chk({tag, "_zero"}, 32'(bus16.zero), 32'(z));
        chk({tag, "_neg"},  32'(bus16.neg),  32'(n));
    endtask

    // Issue one operation on the 16-bit unit; lat = edges from start edge to done
    task automatic op16(input string tag, input logic sl, input logic [15:0] a,
                        input logic [15:0] b, output int lat);
        logic [15:0] prev_s;
        bit got;
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.sel   = sl;
        bus16.a     = a;
        bus16.b     = b;
        prev_s      = bus16.s;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.a     = 16'hDEAD;
        bus16.b     = 16'hBEEF;
        bus16.sel   = ~sl;
        chk({tag, "_busy"}, 32'(bus16.busy), 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus16.done) got = 1'b1;
            else chk({tag, "_hold"}, 32'(bus16.s), 32'(prev_s));
        end
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else chk({tag, "_busy_at_done"}, 32'(bus16.busy), 32'd0);
    endtask

    int lat, e, dones, first, lat8, lat1;
    logic [15:0] s_at_done;

    initial begin
        rst_n = 1'b0;
        bus16.start = 1'b0; bus16.sel = 1'b0; bus16.a = '0; bus16.b = '0;
        bus8.start  = 1'b0; bus8.sel  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        bus1.start  = 1'b0; bus1.sel  = 1'b0; bus1.a  = '0; bus1.b  = '0;
        #1;
        chk_res16("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", 32'(bus16.busy), 32'd0);
        chk("reset_done", 32'(bus16.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op16("add1", 1'b0, 16'h1234, 16'h0FCD, lat);
        chk("add1_lat", 32'(lat), 32'd4);
        chk_res16("add1", 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0);

        op16("sub1", 1'b1, 16'h0005, 16'h0007, lat);
        chk_res16("sub1", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);

        op16("sub2", 1'b1, 16'h00FF, 16'h00FF, lat);
        chk_res16("sub2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        op16("ovfadd", 1'b0, 16'h7FFF, 16'h0001, lat);
        chk_res16("ovfadd", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Back-to-back: start held during the DONE cycle
        op16("b2b1", 1'b0, 16'h0001, 16'h0002, lat);
        chk_res16("b2b1", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        bus16.start = 1'b1; bus16.sel = 1'b0; bus16.a = 16'h0010; bus16.b = 16'h0020;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        chk("b2b2_busy", 32'(bus16.busy), 32'd1);
        e = 1;
        while (!bus16.done && e < 20) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk("b2b2_done_gap", 32'(e), 32'd5);
        chk_res16("b2b2", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start re-pulsed two cycles into RUN must be ignored
        @(negedge clk);
        bus16.start = 1'b1; bus16.sel = 1'b0; bus16.a = 16'h1111; bus16.b = 16'h2222;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus16.start = 1'b1; bus16.sel = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'h0001;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        e = 3; dones = 0; first = 0; s_at_done = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (bus16.done) begin
                dones++;
                if (first == 0) begin
                    first = e;
                    s_at_done = bus16.s;
                end
            end
        end
        chk("ign_lat", 32'(first), 32'd4);
        chk("ign_dones", 32'(dones), 32'd1);
        chk("ign_s_done", 32'(s_at_done), 32'h3333);
        chk_res16("ign_final", 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);

        op16("ovfsub", 1'b1, 16'h8000, 16'h0001, lat);
        chk_res16("ovfsub", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN (k=2)
        @(negedge clk);
        bus16.start = 1'b1; bus16.sel = 1'b0; bus16.a = 16'h1234; bus16.b = 16'h0FCD;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_res16("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_busy", 32'(bus16.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", 32'(bus16.done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op16("postrst", 1'b0, 16'h0003, 16'h0004, lat);
        chk("postrst_lat", 32'(lat), 32'd4);
        chk_res16("postrst", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

        // Parameter sweep: 8/8 and 8/1 run 0xFF + 0x01 together
        @(negedge clk);
        bus8.start = 1'b1; bus8.sel = 1'b0; bus8.a = 8'hFF; bus8.b = 8'h01;
        bus1.start = 1'b1; bus1.sel = 1'b0; bus1.a = 8'hFF; bus1.b = 8'h01;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        e = 0; lat8 = 0; lat1 = 0;
        while ((lat8 == 0 || lat1 == 0) && e < 30) begin
            @(posedge clk);
            #1;
            e++;
            if (bus8.done && lat8 == 0) lat8 = e;
            if (bus1.done && lat1 == 0) lat1 = e;
        end
        chk("w8c8_lat", 32'(lat8), 32'd1);
        chk("w8c1_lat", 32'(lat1), 32'd8);
        chk("w8c8_s",    32'(bus8.s),    32'h00);
        chk("w8c8_cout", 32'(bus8.cout), 32'd1);
        chk("w8c8_zero", 32'(bus8.zero), 32'd1);
        chk("w8c8_ovf",  32'(bus8.ovf),  32'd0);
        chk("w8c1_s",    32'(bus1.s),    32'h00);
        chk("w8c1_cout", 32'(bus1.cout), 32'd1);
        chk("w8c1_zero", 32'(bus1.zero), 32'd1);
        chk("w8c1_ovf",  32'(bus1.ovf),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/addsub_serial_unit.md
# addsub_serial_unit

Parametrised digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands CHUNK bits per clock, lowest chunk first, and reports carry, signed-overflow, zero and negative flags. It is the next generation of the 8-bit ripple add/sub datapath. It trades latency for area and timing at large WIDTH, and adds a start/done handshake. It sits between the operand registers and the result/flag registers of the arithmetic unit.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: N = WIDTH/CHUNK, cycles per operation.

- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled on rising edge.
- sel  in  1  0: add, 1: subtract (A − B); sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result and flags valid.
- S  out  WIDTH  result.
- cout  out  1  final carry out; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  two's-complement overflow.
- zero  out  1  S == 0.
- neg  out  1  S[WIDTH-1].

## Operation
- State machine IDLE → RUN → DONE → IDLE.
- **IDLE**, or **DONE** with start=1:
  - latch A, B, sel;
  - set carry register = sel;
  - set chunk index k = 0;
  - go to RUN.
- **RUN**, each cycle:
  - chunk k of S = A_k + (B_k XOR {CHUNK{sel}}) + carry;
  - carry ← chunk carry-out;
  - k ← k+1.
  - After chunk N−1 completes, go to DONE.
- **On the last chunk**:
  - cout = carry out of bit WIDTH−1;
  - ovf = carry into MSB XOR carry out of MSB;
  - zero and neg are computed from the complete S.
- **DONE** lasts exactly one cycle. With start=0 it returns to IDLE.
- **Output holding**:
  - S and flags hold their values from DONE until the next accepted start.
  - While RUN is in progress, S and flags hold the previous operation's values.
  - Partial S is built in an internal shift/accumulate register, never on the output ports.
- **start while RUN**: ignored; the operation is not restarted and operands are not re-sampled.
- **A, B, sel** may change freely after the start-sampling edge.
- **N = 1 (CHUNK = WIDTH)**: single RUN cycle; behaviour is otherwise identical.

## Timing
- **Reset values** (asynchronous, immediate):
  - S = 0; cout, ovf, zero, neg, busy, done = 0;
  - state IDLE; internal carry and k cleared.
- **Mid-operation reset**: the operation is aborted with no done pulse. After release, the unit is in IDLE and accepts start on the first rising edge.
- **Latency**: start sampled at edge 0.
  - busy = 1 from after edge 0 through edge N.
  - Chunks are processed at edges 1..N.
  - done = 1 and S/flags are valid in the cycle after edge N.
  - Total: N+1 cycles, start edge to done.
- **Back-to-back**: start held high in the DONE cycle is accepted. Throughput is one operation per N+1 cycles.
- done and busy are never high together.

## Structure
- **Package addsub_pkg** holds:
  - state enum {IDLE, RUN, DONE};
  - function for the index width, clog2(N) with a minimum of 1;
  - parameter legality check (WIDTH % CHUNK == 0), raising an elaboration error on failure.
- **One sub-module: addsub_chunk.**
  - Combinational CHUNK-bit add/sub slice.
  - Inputs: a, b, sel, cin. Outputs: s, cout, c_msb_in (carry into the slice MSB, used for ovf).
  - Generalises the per-bit add/sub cell.
- The top level holds the FSM, operand shift registers, carry register, chunk counter, result accumulator, and output/flag registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless noted.
- Reset, then add 0x1234 + 0x0FCD → done 5 cycles after start; S=0x2201, cout=0, ovf=0, zero=0, neg=0.
- Subtract 0x0005 − 0x0007 → S=0xFFFE, cout=0, ovf=0, neg=1. Subtract 0x00FF − 0x00FF → S=0x0000, cout=1, zero=1.
- Overflow:
  - add 0x7FFF + 0x0001 → S=0x8000, ovf=1, neg=1, cout=0;
  - subtract 0x8000 − 0x0001 → S=0x7FFF, ovf=1, cout=1.
- Handshake:
  - pulse start again 2 cycles into RUN with different operands → ignored; the first result is unchanged and done pulses once.
  - hold start high through the DONE cycle → second operation accepted; its done comes N+1 cycles later.
- Reset asserted at k=2 of an operation → all outputs immediately 0, no done pulse; a new start after release gives a correct result.
- Parameter sweep:
  - WIDTH=8, CHUNK=8: 0xFF + 0x01 → S=0x00, cout=1, zero=1, done 2 cycles after start;
  - WIDTH=8, CHUNK=1: the same operation completes in 9 cycles.
